// File: rtl/app_src_feeder.sv
// app_src_feeder: host valid/ready FIFO feeding the injector's credit-based source port,
// with application framing tracking and end-of-applications gating on a clean boundary.
module app_src_feeder #(
   parameter int DEPTH     = 8,
   parameter int FLIT_SIZE = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 host_valid_i,
   output logic                 host_ready_o,
   input  logic [FLIT_SIZE-1:0] host_data_i,
   input  logic                 host_eoa_i,
   output logic                 src_rx_o,
   input  logic                 src_credit_i,
   output logic [FLIT_SIZE-1:0] src_data_o,
   output logic                 src_eoa_o,
   output logic [15:0]          app_count_o,
   output logic                 err_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {HEADER, PAYLOAD} state_t;
   logic [FLIT_SIZE-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [AW:0]          r_count;
   state_t               r_state;
   logic [31:0]          r_rem;
   logic                 r_eoa_pending, r_src_eoa, r_err;
   logic [15:0]          r_app_count;
   logic                 w_full, w_empty, w_push, w_pop;
   logic [FLIT_SIZE-1:0] w_head;
   logic [31:0]          w_hdr;
   assign w_full       = r_count == (AW+1)'(DEPTH);
   assign w_empty      = r_count == '0;
   assign host_ready_o = !w_full && !r_eoa_pending;
   assign w_push       = host_valid_i && host_ready_o;
   assign src_rx_o     = !w_empty;
   assign w_pop        = src_rx_o && src_credit_i;
   assign w_head       = r_mem[r_rptr];
   assign w_hdr        = 32'(w_head);
   assign src_data_o   = w_head;
   assign src_eoa_o    = r_src_eoa;
   assign app_count_o  = r_app_count;
   assign err_o        = r_err;
   // Storage is deliberately left unreset; only the pointers define valid contents.
   always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wptr] <= host_data_i;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_state       <= HEADER;
         r_rem         <= '0;
         r_eoa_pending <= 1'b0;
         r_src_eoa     <= 1'b0;
         r_err         <= 1'b0;
         r_app_count   <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (host_eoa_i) r_eoa_pending <= 1'b1;
         if (r_eoa_pending && w_empty && r_state == HEADER) r_src_eoa <= 1'b1;
         if (w_pop) begin
            if (r_state == HEADER) begin
               if (w_head == '0) r_err <= 1'b1;
               else begin
                  r_rem   <= w_hdr;
                  r_state <= PAYLOAD;
               end
            end else begin
               r_rem <= r_rem - 32'd1;
               if (r_rem == 32'd1) begin
                  r_app_count <= r_app_count + 16'd1;
                  r_state     <= HEADER;
               end
            end
         end
      end
endmodule

// File: tb/tb_app_src_feeder.sv
// tb_app_src_feeder: directed checks of app_src_feeder against hand-computed word sequences.
module tb_app_src_feeder;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        host_valid_i = 1'b0;
   logic        host_ready_o;
   logic [31:0] host_data_i = '0;
   logic        host_eoa_i = 1'b0;
   logic        src_rx_o;
   logic        src_credit_i = 1'b0;
   logic [31:0] src_data_o;
   logic        src_eoa_o;
   logic [15:0] app_count_o;
   logic        err_o;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] w [0:31];
   int          p, q, nw;
   app_src_feeder #(.DEPTH(8), .FLIT_SIZE(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
      .host_data_i(host_data_i), .host_eoa_i(host_eoa_i),
      .src_rx_o(src_rx_o), .src_credit_i(src_credit_i), .src_data_o(src_data_o),
      .src_eoa_o(src_eoa_o), .app_count_o(app_count_o), .err_o(err_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("rst_ready", 32'(host_ready_o), 32'd1);
      check("rst_rx", 32'(src_rx_o), 32'd0);
      check("rst_eoa", 32'(src_eoa_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_count", 32'(app_count_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      p = 0;
      q = 0;
   endtask
   // Runs from one negedge to the next: offers w[p], checks any pop against w[q].
   task automatic run(input int cyc);
      logic pushing;
      for (int c = 0; c < cyc; c++) begin
         host_valid_i = p < nw;
         host_data_i  = (p < nw) ? w[p] : 32'd0;
         if (src_rx_o && src_credit_i) begin
            check("pop_data", src_data_o, w[q]);
            q++;
         end
         pushing = host_valid_i && host_ready_o;
         @(negedge clk_i);
         if (pushing) p++;
      end
      host_valid_i = 1'b0;
   endtask
   initial begin
      p = 0; q = 0; nw = 0;
      do_reset();
      // single application with continuous credit
      w[0] = 32'd3; w[1] = 32'hA; w[2] = 32'hB; w[3] = 32'hC; nw = 4;
      src_credit_i = 1'b1;
      run(4);
      check("sa_consecutive", 32'(q), 32'd3);
      check("sa_head_c", src_data_o, 32'hC);
      host_eoa_i = 1'b1;
      @(negedge clk_i);
      host_eoa_i = 1'b0;
      check("sa_count", 32'(app_count_o), 32'd1);
      check("sa_eoa_early", 32'(src_eoa_o), 32'd0);
      check("sa_ready_eoa", 32'(host_ready_o), 32'd0);
      check("sa_rx_empty", 32'(src_rx_o), 32'd0);
      @(negedge clk_i);
      check("sa_eoa", 32'(src_eoa_o), 32'd1);
      // backpressure: ten words offered into an eight-deep FIFO
      do_reset();
      for (int i = 0; i < 10; i++) w[i] = 32'h100 + 32'(i);
      nw = 10;
      src_credit_i = 1'b0;
      run(8);
      check("bp_ready_full", 32'(host_ready_o), 32'd0);
      check("bp_rx", 32'(src_rx_o), 32'd1);
      check("bp_head", src_data_o, 32'h100);
      run(3);
      check("bp_head_hold", src_data_o, 32'h100);
      check("bp_no_push", 32'(p), 32'd8);
      src_credit_i = 1'b1;
      run(14);
      check("bp_delivered", 32'(q), 32'd10);
      check("bp_empty", 32'(src_rx_o), 32'd0);
      check("bp_ready_again", 32'(host_ready_o), 32'd1);
      // steady streaming at half occupancy
      for (int i = 0; i < 24; i++) w[i] = 32'h200 + 32'(i);
      p = 0; q = 0; nw = 24;
      src_credit_i = 1'b0;
      run(4);
      src_credit_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("ss_ready", 32'(host_ready_o), 32'd1);
         check("ss_rx", 32'(src_rx_o), 32'd1);
         run(1);
      end
      check("ss_pushed", 32'(p), 32'd24);
      check("ss_popped", 32'(q), 32'd20);
      run(6);
      check("ss_drained", 32'(q), 32'd24);
      check("ss_empty", 32'(src_rx_o), 32'd0);
      // zero header flags an error and the next header frames normally
      do_reset();
      w[0] = 32'd0; w[1] = 32'd1; w[2] = 32'h55; nw = 3;
      src_credit_i = 1'b1;
      run(3);
      check("zh_err", 32'(err_o), 32'd1);
      check("zh_count0", 32'(app_count_o), 32'd0);
      run(2);
      check("zh_popped", 32'(q), 32'd3);
      check("zh_count1", 32'(app_count_o), 32'd1);
      // EOA requested mid-application never completes
      do_reset();
      w[0] = 32'd4; w[1] = 32'd1; w[2] = 32'd2; nw = 3;
      src_credit_i = 1'b1;
      run(3);
      host_eoa_i = 1'b1;
      run(1);
      host_eoa_i = 1'b0;
      check("em_popped", 32'(q), 32'd3);
      for (int i = 0; i < 50; i++) begin
         check("em_eoa_low", 32'(src_eoa_o), 32'd0);
         check("em_ready_low", 32'(host_ready_o), 32'd0);
         @(negedge clk_i);
      end
      check("em_err", 32'(err_o), 32'd0);
      check("em_count", 32'(app_count_o), 32'd0);
      // reset while mid-payload with five words queued
      do_reset();
      w[0] = 32'd5;
      for (int i = 1; i < 7; i++) w[i] = 32'h10 + 32'(i);
      nw = 7;
      src_credit_i = 1'b0;
      run(5);
      src_credit_i = 1'b1;
      run(2);
      src_credit_i = 1'b0;
      check("rm_pushed", 32'(p), 32'd7);
      check("rm_rx_before", 32'(src_rx_o), 32'd1);
      do_reset();
      w[0] = 32'd1; w[1] = 32'h77; nw = 2;
      src_credit_i = 1'b1;
      run(4);
      check("rm_popped", 32'(q), 32'd2);
      check("rm_count", 32'(app_count_o), 32'd1);
      check("rm_err", 32'(err_o), 32'd0);
      check("rm_empty", 32'(src_rx_o), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
